// File: rtl/sent_pkg.sv
// Shared constants and types for the SENT CRC logic.
// The RX checker uses the same seeds, polynomials and chunk ordering.
package sent_pkg;

    // 4-bit CRC: x^4+x^3+x^2+1. 6-bit CRC: x^6+x^4+x^3+1.
    localparam logic [3:0] SEED4 = 4'b0101;
    localparam logic [4:0] POLY4 = 5'b11101;
    localparam logic [5:0] SEED6 = 6'b010101;
    localparam logic [6:0] POLY6 = 7'b1011001;

    typedef enum logic [2:0] {
        MODE_FAST3  = 3'd0,
        MODE_FAST4  = 3'd1,
        MODE_FAST6  = 3'd2,
        MODE_SERIAL = 3'd3,
        MODE_ENH    = 3'd4
    } sent_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Steps per mode: data chunks plus one all-zero augmentation chunk.
    localparam logic [2:0] STEPS_FAST3  = 3'd4;
    localparam logic [2:0] STEPS_FAST4  = 3'd5;
    localparam logic [2:0] STEPS_FAST6  = 3'd7;
    localparam logic [2:0] STEPS_SERIAL = 3'd4;
    localparam logic [2:0] STEPS_ENH    = 3'd5;

    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m <= MODE_ENH);
    endfunction

    // Counter value at which the final step is applied.
    function automatic logic [2:0] last_step(input sent_mode_e m);
        case (m)
            MODE_FAST4:  return STEPS_FAST4 - 3'd1;
            MODE_FAST6:  return STEPS_FAST6 - 3'd1;
            MODE_SERIAL: return STEPS_SERIAL - 3'd1;
            MODE_ENH:    return STEPS_ENH - 3'd1;
            default:     return STEPS_FAST3 - 3'd1;
        endcase
    endfunction

    // Move the right-justified payload to the top of the shift register so
    // every mode consumes chunks from bit 23 downward; zeros shifted in
    // behind the data form the augmentation chunk for free.
    function automatic logic [23:0] left_justify(input sent_mode_e m, input logic [23:0] d);
        case (m)
            MODE_FAST4:           return {d[15:0], 8'h00};
            MODE_FAST6, MODE_ENH: return d;
            default:              return {d[11:0], 12'h000};
        endcase
    endfunction

endpackage

// File: rtl/sent_crc_step.sv
// Combinational one-chunk CRC update, MSB of the chunk first.
// poly_i is the generator without its implicit top term (x^CRC_W).
module sent_crc_step #(
    parameter int CRC_W   = 4,
    parameter int CHUNK_W = 4
) (
    input  logic [CRC_W-1:0]   crc_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    input  logic [CRC_W-1:0]   poly_i,
    output logic [CRC_W-1:0]   crc_o
);

    logic [CRC_W-1:0] r;

    // Shift each chunk bit into the remainder, folding in the polynomial
    // whenever the bit falling off the top is set.
    always_comb begin
        // NOTE: blocking assignments here so each loop iteration sees the
        // previous iteration's value of r within the same evaluation.
        r = crc_i;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            r = {r[CRC_W-2:0], chunk_i[i]} ^ (r[CRC_W-1] ? poly_i : '0);
        end
        crc_o = r;
    end

endmodule

// File: rtl/sent_tx_crc_gen.sv
// SENT transmit CRC generator: accepts a payload and mode, then computes
// the CRC one chunk per clock and reports it with a single-cycle pulse.
module sent_tx_crc_gen
    import sent_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [23:0] data_in,
    output logic        ready,
    output logic        busy,
    output logic        crc_valid,
    output logic        crc_err,
    output logic [5:0]  crc_out
);

    state_e      state_q, state_d;
    sent_mode_e  mode_q, mode_d;
    logic [23:0] shift_q, shift_d;
    logic [5:0]  crc_q, crc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [3:0]  crc4_nxt;
    logic [5:0]  crc6_nxt;

    sent_crc_step #(.CRC_W(4), .CHUNK_W(4)) u_step4 (
        .crc_i   (crc_q[3:0]),
        .chunk_i (shift_q[23:20]),
        .poly_i  (POLY4[3:0]),
        .crc_o   (crc4_nxt)
    );

    sent_crc_step #(.CRC_W(6), .CHUNK_W(6)) u_step6 (
        .crc_i   (crc_q),
        .chunk_i (shift_q[23:18]),
        .poly_i  (POLY6[5:0]),
        .crc_o   (crc6_nxt)
    );

    // State, latched payload/mode, CRC register and step counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every
        // register updates from pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FAST3;
            shift_q <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept in IDLE, one chunk per cycle in RUN, pulse in DONE.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (mode_is_legal(mode)) begin
                        mode_d  = sent_mode_e'(mode);
                        shift_d = left_justify(sent_mode_e'(mode), data_in);
                        crc_d   = (mode == MODE_ENH) ? SEED6 : {2'b00, SEED4};
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        crc_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (mode_q == MODE_ENH) begin
                    crc_d   = crc6_nxt;
                    shift_d = {shift_q[17:0], 6'b0};
                end else begin
                    crc_d   = {2'b00, crc4_nxt};
                    shift_d = {shift_q[19:0], 4'b0};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == last_step(mode_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    // Reset suppresses a pulse already on the wire so no result escapes.
    assign crc_valid = (state_q == ST_DONE) && !reset;
    assign crc_err   = err_q;
    assign crc_out   = crc_q;

endmodule

// File: tb/tb_sent_tx_crc_gen.sv
// Scoreboard bench for sent_tx_crc_gen: the driver queues expected results,
// the monitor pops and compares on every crc_valid pulse.
module tb_sent_tx_crc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic [23:0] data_in;
    logic        ready, busy, crc_valid, crc_err;
    logic [5:0]  crc_out;

    int n_checks = 0;
    int n_miss   = 0;
    int cyc      = 0;

    localparam logic [3:0] R_SEED4 = 4'b0101;
    localparam logic [4:0] R_POLY4 = 5'b11101;
    localparam logic [5:0] R_SEED6 = 6'b010101;
    localparam logic [6:0] R_POLY6 = 7'b1011001;

    typedef struct {
        logic [5:0]  crc;
        logic        err;
        int          issue;
        int          lat;
        logic [2:0]  mode;
        logic [23:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t me;

    sent_tx_crc_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .data_in   (data_in),
        .ready     (ready),
        .busy      (busy),
        .crc_valid (crc_valid),
        .crc_err   (crc_err),
        .crc_out   (crc_out)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int steps_of(input logic [2:0] m);
        case (m)
            3'd0, 3'd3: return 4;
            3'd1:       return 5;
            3'd2:       return 7;
            3'd4:       return 5;
            default:    return 0;
        endcase
    endfunction

    // Long division of {seed, payload, tail}; tail=0 gives the CRC,
    // tail=CRC gives the receiver's remainder (expected zero).
    function automatic logic [5:0] div_rem(input logic [2:0] m, input logic [23:0] d,
                                           input logic [5:0] tail);
        logic [63:0] msg, poly, mask_w;
        int w, nd, nb;
        if (m == 3'd4) begin
            w = 6; nd = 24;
            msg = {58'd0, R_SEED6}; poly = {57'd0, R_POLY6};
        end else begin
            w = 4; nd = (m == 3'd1) ? 16 : (m == 3'd2) ? 24 : 12;
            msg = {60'd0, R_SEED4}; poly = {59'd0, R_POLY4};
        end
        mask_w = (64'd1 << w) - 64'd1;
        msg = (msg << nd) | ({40'd0, d} & ((64'd1 << nd) - 64'd1));
        msg = (msg << w) | ({58'd0, tail} & mask_w);
        nb = w + nd + w;
        for (int i = nb - 1; i >= w; i--) begin
            if (msg[i]) msg = msg ^ (poly << (i - w));
        end
        return 6'(msg & mask_w);
    endfunction

    // Monitor: every crc_valid must match the oldest queued expectation.
    logic       hold_pend = 1'b0;
    logic [5:0] hold_val  = '0;
    initial forever begin
        @(negedge clk);
        if (crc_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(crc_valid), 32'd0);
            end else begin
                me = sb_q.pop_front();
                check({me.name, "_crc"}, 32'(crc_out), 32'(me.crc));
                check({me.name, "_err"}, 32'(crc_err), 32'(me.err));
                check({me.name, "_latency"}, cyc - me.issue, me.lat);
                check({me.name, "_ready_low"}, 32'(ready), 32'd0);
                if (!me.err)
                    check({me.name, "_rx_resid"}, 32'(div_rem(me.mode, me.data, crc_out)), 32'd0);
            end
            hold_pend = 1'b1;
            hold_val  = crc_out;
        end else if (hold_pend) begin
            check("hold_after_done", 32'(crc_out), 32'(hold_val));
            hold_pend = 1'b0;
        end
    end

    task automatic wait_ready(input string name);
        int t = 0;
        while (ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) check({name, "_ready_timeout"}, 32'(ready), 32'd1);
    endtask

    // Issue one request at a negedge; optionally disturb inputs during RUN.
    task automatic issue(input logic [2:0] m, input logic [23:0] d, input logic [5:0] exp_crc,
                         input logic exp_err, input string name, input bit disturb);
        exp_t e;
        wait_ready(name);
        mode    = m;
        data_in = d;
        start   = 1'b1;
        e.crc   = exp_crc;
        e.err   = exp_err;
        e.issue = cyc;
        e.lat   = exp_err ? 1 : steps_of(m) + 1;
        e.mode  = m;
        e.data  = d;
        e.name  = name;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            for (int k = 0; k < 3; k++) begin
                start   = 1'b1;
                data_in = ~data_in;
                mode    = 3'd1;
                @(negedge clk);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 3'd0;
        data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready",   32'(ready),     32'd1);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_valid",   32'(crc_valid), 32'd0);
        check("rst_err",     32'(crc_err),   32'd0);
        check("rst_crc_out", 32'(crc_out),   32'd0);

        // Hand-computed directed vectors.
        issue(3'd0, 24'h000000, 6'h09, 1'b0, "fast3_zero",  1'b0);
        issue(3'd0, 24'h000001, 6'h04, 1'b0, "fast3_one",   1'b0);
        issue(3'd1, 24'h000000, 6'h0C, 1'b0, "fast4_zero",  1'b0);
        issue(3'd2, 24'h000000, 6'h05, 1'b0, "fast6_zero",  1'b0);
        issue(3'd3, 24'h000000, 6'h09, 1'b0, "serial_zero", 1'b0);
        issue(3'd4, 24'h000000, 6'h26, 1'b0, "enh_zero",    1'b0);
        issue(3'd3, 24'hABC001, 6'h04, 1'b0, "serial_hi_ignored", 1'b0);

        // Illegal modes, then a legal run that must clear crc_err.
        issue(3'd6, 24'h123456, 6'h00, 1'b1, "illegal6", 1'b0);
        issue(3'd5, 24'hFFFFFF, 6'h00, 1'b1, "illegal5", 1'b0);
        issue(3'd7, 24'h000000, 6'h00, 1'b1, "illegal7", 1'b0);
        issue(3'd0, 24'h000000, 6'h09, 1'b0, "fast3_after_err", 1'b0);

        // start pulses and data/mode changes while busy have no effect.
        issue(3'd4, 24'h000000, 6'h26, 1'b0, "enh_disturbed",   1'b1);
        issue(3'd2, 24'h000000, 6'h05, 1'b0, "fast6_disturbed", 1'b1);

        // Pseudo-random payloads across all legal modes.
        for (int k = 0; k < 10; k++) begin
            logic [2:0]  m;
            logic [23:0] d;
            m = 3'(k % 5);
            d = 24'($urandom);
            issue(m, d, div_rem(m, d, 6'd0), 1'b0, "rand", 1'b0);
        end

        // Reset mid-RUN, with start coincident with reset.
        wait_ready("rst_mid");
        mode    = 3'd2;
        data_in = 24'h123456;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        mode  = 3'd0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_mid_ready", 32'(ready),     32'd1);
        check("rst_mid_busy",  32'(busy),      32'd0);
        check("rst_mid_valid", 32'(crc_valid), 32'd0);
        repeat (12) @(negedge clk);
        check("rst_mid_still_idle", 32'(ready), 32'd1);

        begin
            int t = 0;
            while (sb_q.size() != 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
